// File: rtl/mvm_controller.sv
// Sequencer for the matrix-vector datapath: streams X and A into memory, runs the MAC schedule
// into memY, then hands the M results out over valid/ready. Optional MVM_PERF_CNT_EN adds cycle_count.
module mvm_controller #(
  parameter int unsigned M   = 3,
  parameter int unsigned N   = 3,
  parameter int unsigned XAW = 4,
  parameter int unsigned VAW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           s_valid,
  output logic           s_ready,
  output logic           m_valid,
  input  logic           m_ready,
  output logic           m_last,
  output logic [XAW-1:0] addr_x,
  output logic           wr_en_x,
  output logic [VAW-1:0] addr_a,
  output logic           wr_en_a,
  output logic [VAW-1:0] addr_y,
  output logic           wr_en_y,
  output logic           clear_acc,
  output logic           busy,
  output logic           done
`ifdef MVM_PERF_CNT_EN
  ,
  output logic [15:0]    cycle_count
`endif
);

  localparam int unsigned NX = M * N;
  localparam int unsigned NW = M * N + N;
  localparam int unsigned LW = $clog2(NW + 1);
  localparam int unsigned RW = $clog2(M + 1);
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_COMP  = 2'd1;
  localparam logic [1:0] ST_PRIME = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] row_q, row_d;  // COMP row, then result index in PRIME/OUT
  logic [CW-1:0] col_q, col_d;
  logic          done_q, done_d;
  logic          load_last;

  assign load_last = (state_q == ST_LOAD) && s_valid && (wcnt_q == LW'(NW - 1));

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    row_d     = row_q;
    col_d     = col_q;
    done_d    = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    addr_x    = '0;
    wr_en_x   = 1'b0;
    addr_a    = '0;
    wr_en_a   = 1'b0;
    addr_y    = '0;
    wr_en_y   = 1'b0;
    clear_acc = 1'b0;
    busy      = (state_q != ST_LOAD);
    done      = done_q;
    case (state_q)
      ST_LOAD: begin
        s_ready = 1'b1;
        if (wcnt_q < LW'(NX)) begin
          addr_x  = XAW'(wcnt_q);
          wr_en_x = s_valid;
        end else begin
          addr_a  = VAW'(wcnt_q - LW'(NX));
          wr_en_a = s_valid;
        end
        if (load_last) begin
          wcnt_d  = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_COMP;
        end else if (s_valid) begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_COMP: begin
        // Column 0 of row i doubles as the Y write slot of row i-1.
        if (col_q == '0) begin
          clear_acc = (row_q != RW'(M));
          if (row_q != '0) begin
            wr_en_y = 1'b1;
            addr_y  = VAW'(row_q - 1'b1);
          end
        end
        if (col_q != CW'(N) && row_q != RW'(M)) begin
          addr_x = XAW'(row_q * N + col_q);
          addr_a = VAW'(col_q);
        end
        if (row_q == RW'(M)) begin
          row_d   = '0;
          col_d   = '0;
          state_d = ST_PRIME;
        end else if (col_q == CW'(N)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      ST_PRIME: begin
        addr_y  = VAW'(row_q);
        state_d = ST_OUT;
      end
      default: begin
        m_valid = 1'b1;
        addr_y  = VAW'(row_q);
        m_last  = (row_q == RW'(M - 1));
        if (m_ready) begin
          if (m_last) begin
            done_d  = 1'b1;
            row_d   = '0;
            state_d = ST_LOAD;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = ST_PRIME;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_LOAD;
      wcnt_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

`ifdef MVM_PERF_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  // Counts every busy cycle plus the done cycle that closes the job.
  always_comb begin
    cyc_d = cyc_q;
    if (load_last) begin
      cyc_d = '0;
    end else if ((state_q != ST_LOAD || done_q) && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`endif

endmodule
